// File: rtl/circ_buf_pkg.sv
// Shared types and sizing helpers for the column-wise circular buffer controller.
//   state_t   : controller phase, 2-bit encoding IDLE=0, RUN=1, DRAIN=2
//   ptr_w()   : pointer width for a ring of 'cols' columns (min 1 bit)
//   cnt_w()   : occupancy width, one bit wider than the pointer so COLUMNS fits
package circ_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_COLUMNS = 32;

  function automatic int ptr_w(input int cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

  function automatic int cnt_w(input int cols);
    return ptr_w(cols) + 1;
  endfunction

endpackage

// File: rtl/circ_buf_ctrl_ptr_wrap_adv.sv
// Registered ring pointer with modulo-COLUMNS wrap.
//   clk, rst : clock, async active-low reset (pointer -> 0)
//   clr      : synchronous clear to 0 (new run)
//   adv      : advance by STEP this cycle
//   ptr      : current pointer, 0..COLUMNS-1
module ptr_wrap_adv #(
  parameter int COLUMNS = 32,
  parameter int STEP    = 1,
  parameter int PW      = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [PW-1:0] ptr
);

  localparam logic [PW:0] STEP_V = (PW+1)'(STEP);
  localparam logic [PW:0] COL_V  = (PW+1)'(COLUMNS);

  // ptr < COLUMNS and STEP <= COLUMNS, so one conditional subtract is enough
  // and the sum never overflows PW+1 bits.
  logic [PW:0] sum;
  logic [PW:0] wrapped;

  always_comb begin
    sum     = {1'b0, ptr} + STEP_V;
    wrapped = (sum >= COL_V) ? (sum - COL_V) : sum;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     ptr <= '0;
    else if (clr) ptr <= '0;
    else if (adv) ptr <= wrapped[PW-1:0];
  end

endmodule

// File: rtl/circ_buf_ctrl.sv
// Circular buffer controller: owns write/read pointers and occupancy, gates
// PAR_WRITE-column write beats and PAR_READ-column read beats with
// valid/ready, and sequences IDLE -> RUN -> DRAIN -> IDLE.
//   clk, rst            : clock, async active-low reset
//   start, drain        : phase requests (levels)
//   wr_valid/wr_ready   : producer handshake; wr_en = accepted write strobe
//   write_ptr           : first column of the current write beat
//   rd_valid/rd_ready   : consumer handshake
//   read_ptr            : first column of the current read beat
//   count, full, empty  : occupancy, 0..COLUMNS
//   busy                : state != IDLE
module circ_buf_ctrl
  import circ_buf_pkg::*;
#(
  parameter int COLUMNS   = DEF_COLUMNS,
  parameter int PAR_WRITE = 4,
  parameter int PAR_READ  = 1,
  localparam int PW = ptr_w(COLUMNS),
  localparam int CW = cnt_w(COLUMNS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          drain,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic          wr_en,
  output logic [PW-1:0] write_ptr,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [PW-1:0] read_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          busy
);

  localparam logic [CW-1:0] COL_C = CW'(COLUMNS);
  localparam logic [CW-1:0] PWR_C = CW'(PAR_WRITE);
  localparam logic [CW-1:0] PRD_C = CW'(PAR_READ);
  localparam logic [CW-1:0] WLIM  = CW'(COLUMNS - PAR_WRITE);

  state_t        state, state_nxt;
  logic          clr;
  logic          rd_en;
  logic [CW-1:0] cnt_nxt;

  // Ready/valid come from registered count only: a read in the same cycle
  // never frees space for a write.
  assign wr_ready = (state == RUN) && (count <= WLIM);
  assign rd_valid = (state != IDLE) && (count >= PRD_C);
  assign wr_en    = wr_valid & wr_ready;
  assign rd_en    = rd_valid & rd_ready;
  assign full     = (count == COL_C);
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign cnt_nxt  = count + (wr_en ? PWR_C : '0) - (rd_en ? PRD_C : '0);

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    case (state)
      IDLE:    if (start) begin state_nxt = RUN; clr = 1'b1; end
      RUN:     if (drain) state_nxt = DRAIN;
      DRAIN:   if (cnt_nxt < PRD_C) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Leaving DRAIN drops any sub-beat remainder; pointers hold until next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    count <= '0;
    else if (clr)                                count <= '0;
    else if (state == DRAIN && state_nxt == IDLE) count <= '0;
    else                                         count <= cnt_nxt;
  end

  ptr_wrap_adv #(.COLUMNS(COLUMNS), .STEP(PAR_WRITE), .PW(PW)) u_wptr (
    .clk(clk), .rst(rst), .clr(clr), .adv(wr_en), .ptr(write_ptr)
  );

  ptr_wrap_adv #(.COLUMNS(COLUMNS), .STEP(PAR_READ), .PW(PW)) u_rptr (
    .clk(clk), .rst(rst), .clr(clr), .adv(rd_en), .ptr(read_ptr)
  );

endmodule

// File: tb/tb_circ_buf_ctrl.sv
module tb_circ_buf_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // main DUT: COLUMNS=32, PAR_WRITE=4, PAR_READ=1
  logic       start = 0, drain = 0, wr_valid = 0, rd_ready = 0;
  logic       wr_ready, wr_en, rd_valid, full, empty, busy;
  logic [4:0] write_ptr, read_ptr;
  logic [5:0] count;

  circ_buf_ctrl #(.COLUMNS(32), .PAR_WRITE(4), .PAR_READ(1)) dut (
    .clk(clk), .rst(rst), .start(start), .drain(drain),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_en(wr_en), .write_ptr(write_ptr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .read_ptr(read_ptr),
    .count(count), .full(full), .empty(empty), .busy(busy)
  );

  // wrap DUT: COLUMNS=30, PAR_WRITE=4, PAR_READ=4
  logic       b_start = 0, b_drain = 0, b_wr_valid = 0, b_rd_ready = 0;
  logic       b_wr_ready, b_wr_en, b_rd_valid, b_full, b_empty, b_busy;
  logic [4:0] b_write_ptr, b_read_ptr;
  logic [5:0] b_count;

  circ_buf_ctrl #(.COLUMNS(30), .PAR_WRITE(4), .PAR_READ(4)) dut2 (
    .clk(clk), .rst(rst), .start(b_start), .drain(b_drain),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_en(b_wr_en), .write_ptr(b_write_ptr),
    .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .read_ptr(b_read_ptr),
    .count(b_count), .full(b_full), .empty(b_empty), .busy(b_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({write_ptr, read_ptr, count} !== 16'd0) begin n_err++;
      $display("FAIL reset_ptrs: wp=%0d rp=%0d cnt=%0d, want 0/0/0", write_ptr, read_ptr, count); end
    n_cmp++; if ({wr_ready, rd_valid, wr_en, full, empty, busy} !== 6'b000010) begin n_err++;
      $display("FAIL reset_flags: wr_ready,rd_valid,wr_en,full,empty,busy=%b, want 000010",
               {wr_ready, rd_valid, wr_en, full, empty, busy}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    int pulses = 0;
    start = 1; tick(); start = 0;
    wr_valid = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (write_ptr !== 5'(i*4) || wr_ready !== 1'b1) begin n_err++;
        $display("FAIL fill_step%0d: wp=%0d wr_ready=%b, want %0d/1", i, write_ptr, wr_ready, i*4); end
      if (wr_en === 1'b1) pulses++;
      tick();
    end
    @(negedge clk);
    if (wr_en === 1'b1) pulses++;
    n_cmp++; if (write_ptr !== 5'd0 || count !== 6'd32 || full !== 1'b1 || wr_ready !== 1'b0) begin n_err++;
      $display("FAIL fill_full: wp=%0d cnt=%0d full=%b wr_ready=%b, want 0/32/1/0",
               write_ptr, count, full, wr_ready); end
    n_cmp++; if (pulses !== 8) begin n_err++;
      $display("FAIL fill_wr_en_pulses: got %0d, want 8", pulses); end
    tick(); wr_valid = 0;
  endtask

  task automatic test_read_from_full();
    rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (read_ptr !== 5'(i) || count !== 6'(32-i) || wr_ready !== 1'b0) begin n_err++;
        $display("FAIL read_step%0d: rp=%0d cnt=%0d wr_ready=%b, want %0d/%0d/0",
                 i, read_ptr, count, wr_ready, i, 32-i); end
      tick();
    end
    rd_ready = 0;
    @(negedge clk);
    n_cmp++; if (read_ptr !== 5'd4 || count !== 6'd28 || wr_ready !== 1'b1) begin n_err++;
      $display("FAIL read_space: rp=%0d cnt=%0d wr_ready=%b, want 4/28/1", read_ptr, count, wr_ready); end
    tick();
  endtask

  task automatic test_back_to_back();
    // bring count 28 -> 10
    rd_ready = 1; repeat (18) tick(); rd_ready = 0;
    @(negedge clk);
    n_cmp++; if (count !== 6'd10 || read_ptr !== 5'd22) begin n_err++;
      $display("FAIL b2b_setup: cnt=%0d rp=%0d, want 10/22", count, read_ptr); end
    tick();
    wr_valid = 1; rd_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (write_ptr !== 5'(i*4) || read_ptr !== 5'(22+i) || wr_en !== 1'b1 || count !== 6'(10+3*i)) begin n_err++;
        $display("FAIL b2b_step%0d: wp=%0d rp=%0d wr_en=%b cnt=%0d, want %0d/%0d/1/%0d",
                 i, write_ptr, read_ptr, wr_en, count, i*4, 22+i, 10+3*i); end
      tick();
    end
    wr_valid = 0; rd_ready = 0;
    @(negedge clk);
    n_cmp++; if (count !== 6'd25 || write_ptr !== 5'd20 || read_ptr !== 5'd27) begin n_err++;
      $display("FAIL b2b_end: cnt=%0d wp=%0d rp=%0d, want 25/20/27", count, write_ptr, read_ptr); end
    tick();
  endtask

  task automatic test_wrap_nondiv();
    b_start = 1; tick(); b_start = 0;
    b_wr_valid = 1; b_rd_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (b_write_ptr !== 5'(i*4) || b_wr_en !== 1'b1) begin n_err++;
        $display("FAIL wrap30_step%0d: wp=%0d wr_en=%b, want %0d/1", i, b_write_ptr, b_wr_en, i*4); end
      tick();
    end
    b_wr_valid = 0; b_rd_ready = 0;
    @(negedge clk);
    n_cmp++; if (b_write_ptr !== 5'd2 || b_read_ptr !== 5'd28 || b_count !== 6'd4) begin n_err++;
      $display("FAIL wrap30_end: wp=%0d rp=%0d cnt=%0d, want 2/28/4", b_write_ptr, b_read_ptr, b_count); end
    tick();
  endtask

  task automatic test_drain();
    // bring count 25 -> 6; read_ptr 27+19 wraps to 14
    rd_ready = 1; repeat (19) tick(); rd_ready = 0;
    @(negedge clk);
    n_cmp++; if (count !== 6'd6 || read_ptr !== 5'd14) begin n_err++;
      $display("FAIL drain_setup: cnt=%0d rp=%0d, want 6/14", count, read_ptr); end
    tick();
    drain = 1; rd_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++; if (busy !== 1'b1 || rd_valid !== 1'b1 || count !== 6'(6-i)) begin n_err++;
        $display("FAIL drain_step%0d: busy=%b rd_valid=%b cnt=%0d, want 1/1/%0d", i, busy, rd_valid, count, 6-i); end
      if (i > 0) begin
        n_cmp++; if (wr_ready !== 1'b0 || wr_en !== 1'b0) begin n_err++;
          $display("FAIL drain_no_write%0d: wr_ready=%b wr_en=%b, want 0/0", i, wr_ready, wr_en); end
      end
      tick();
      wr_valid = 1;  // held valid while draining must not be accepted
    end
    drain = 0; rd_ready = 0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || count !== 6'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || wr_en !== 1'b0) begin n_err++;
      $display("FAIL drain_idle: busy=%b cnt=%0d empty=%b rd_valid=%b wr_en=%b, want 0/0/1/0/0",
               busy, count, empty, rd_valid, wr_en); end
    n_cmp++; if (read_ptr !== 5'd20 || write_ptr !== 5'd20) begin n_err++;
      $display("FAIL drain_ptr_hold: rp=%0d wp=%0d, want 20/20", read_ptr, write_ptr); end
    tick(); wr_valid = 0;
  endtask

  task automatic test_async_reset();
    start = 1; tick(); start = 0;
    wr_valid = 1; repeat (3) tick();
    @(negedge clk);
    n_cmp++; if (count !== 6'd12 || write_ptr !== 5'd12 || wr_en !== 1'b1) begin n_err++;
      $display("FAIL arst_setup: cnt=%0d wp=%0d wr_en=%b, want 12/12/1", count, write_ptr, wr_en); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({write_ptr, read_ptr, count} !== 16'd0 ||
                 {wr_ready, rd_valid, wr_en, full, empty, busy} !== 6'b000010) begin n_err++;
      $display("FAIL arst_immediate: wp=%0d rp=%0d cnt=%0d flags=%b, want 0/0/0/000010",
               write_ptr, read_ptr, count, {wr_ready, rd_valid, wr_en, full, empty, busy}); end
    @(negedge clk); rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || wr_ready !== 1'b0 || count !== 6'd0 || write_ptr !== 5'd0) begin n_err++;
      $display("FAIL arst_stays_idle: busy=%b wr_ready=%b cnt=%0d wp=%0d, want 0/0/0/0",
               busy, wr_ready, count, write_ptr); end
    wr_valid = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_read_from_full();
    test_back_to_back();
    test_wrap_nondiv();
    test_drain();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/circ_buf_ctrl.md
Name: circ_buf_ctrl

Overview:
Controller for the column-wise circular buffer. It owns the write and read pointers and the occupancy count, and it gates parallel writes and reads with valid/ready handshakes. It sequences the buffer through IDLE, RUN and DRAIN phases. It sits between the producer feeding PAR_WRITE columns per beat, the buffer storage, and the consumer taking PAR_READ columns per beat.

Parameters:
COLUMNS, 32, number of buffer columns (ring depth).
PAR_WRITE, 4, columns written per accepted write beat; 1 <= PAR_WRITE <= COLUMNS.
PAR_READ, 1, columns consumed per accepted read beat; 1 <= PAR_READ <= COLUMNS.
PW = $clog2(COLUMNS), pointer width (localparam).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset; asserted when 0, takes effect immediately, released synchronously to clk.
start  in  1  IDLE->RUN request (level, sampled per cycle).
drain  in  1  RUN->DRAIN request (level, sampled per cycle).
wr_valid  in  1  producer has PAR_WRITE columns ready.
wr_ready  out  1  controller accepts a write beat this cycle.
wr_en  out  1  storage write strobe = wr_valid & wr_ready.
write_ptr  out  PW  first column of the current write beat.
rd_valid  out  1  at least PAR_READ columns are available.
rd_ready  in  1  consumer takes a read beat.
read_ptr  out  PW  first column of the current read beat.
count  out  PW+1  occupied columns, 0..COLUMNS.
full  out  1  count == COLUMNS.
empty  out  1  count == 0.
busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0): state=IDLE; write_ptr=0, read_ptr=0, count=0; wr_ready=0, rd_valid=0, wr_en=0; full=0, empty=1, busy=0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE->RUN when start=1. Pointers and count are cleared on this transition.
  - RUN->DRAIN when drain=1. drain has priority over nothing else; start is ignored in RUN.
  - DRAIN->IDLE when count < PAR_READ after the current cycle's update. Any residual columns below PAR_READ are discarded; the pointers keep their values until the next start.
- wr_ready = (state==RUN) & (count <= COLUMNS-PAR_WRITE). It is combinational from registered state, with no dependence on wr_valid.
- rd_valid = (state!=IDLE) & (count >= PAR_READ). It is combinational from registered state.
- Write accept (wr_valid & wr_ready):
  - write_ptr advances by PAR_WRITE modulo COLUMNS, computed in PW+1 bits.
  - If the sum >= COLUMNS, subtract COLUMNS.
  - The new pointer is visible the next cycle. Zero-latency handshake.
- Read accept (rd_valid & rd_ready): read_ptr advances by PAR_READ using the same wrap rule.
- Count update:
  - count_next = count + (wr accepted ? PAR_WRITE : 0) - (rd accepted ? PAR_READ : 0).
  - A simultaneous write and read in one cycle is legal; both pointers update.
  - Because of the ready/valid gating, count never exceeds COLUMNS and never goes negative.
- Full boundary: at count = COLUMNS-PAR_WRITE+1 or higher, wr_ready=0 even if a read is accepted in the same cycle. There is no same-cycle pass-through of space.
- Wrap: write_ptr = COLUMNS-PAR_WRITE with an accepted write gives 0. Non-divisible cases wrap to the remainder (e.g. ptr 30 + 4 with COLUMNS=32 gives 2).
- Reset mid-operation: all state returns to reset values asynchronously. Any in-flight beat is dropped, and wr_en deasserts immediately.
- Writes in DRAIN or IDLE are not accepted (wr_ready=0). A wr_valid held in those states is not an error.

Decomposition:
- Package circ_buf_pkg holds the state enum {IDLE, RUN, DRAIN} with 2-bit encoding 0/1/2, plus the PW and count-width helper constants.
- One natural sub-module: ptr_wrap_adv. It is a registered pointer that takes an advance enable, a parameterized STEP and the async active-low reset, and does modulo-COLUMNS wrap. It is instantiated twice: for write (STEP=PAR_WRITE) and for read (STEP=PAR_READ).
- FSM, count and handshake logic stay in the top module.

Test Plan:
1. Reset then start=1, 8 cycles of wr_valid=1, rd_ready=0 (defaults):
   - write_ptr steps 0,4,...,28 then 0.
   - wr_ready drops once count=32; full=1, count=32.
   - Exactly 8 wr_en pulses.
2. From full, rd_ready=1 for 3 cycles, wr_valid=0:
   - read_ptr goes 0 to 3, count=29.
   - wr_ready=1 only when count<=28, i.e. after the 4th read.
3. Simultaneous write and read, count=10, both valid/ready for 5 cycles: count=25; both pointers advance each cycle.
4. Non-divisible wrap with COLUMNS=30, PAR_WRITE=4: after 8 writes with reads keeping count low, write_ptr=2 (32 mod 30).
5. count=6, drain=1, rd_ready=1:
   - state goes to DRAIN, wr_ready=0.
   - After 6 reads, count=0 and state is IDLE next cycle; busy=0.
6. Assert rst=0 mid-beat, asynchronously between edges, with count=12: all outputs reach reset values before the next edge; the state stays IDLE until start.
